// File: rtl/fg_cordic_pipe_if.sv
// Sample-stream bus for fg_cordic_pipe: request side (x/y/phase/mode) and result side.
interface fg_cordic_pipe_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PHASE_W = 10
);
    logic                      clk_en_i;
    logic                      valid_i;
    logic                      mode_i;
    logic signed [DATA_W-1:0]  x_i;
    logic signed [DATA_W-1:0]  y_i;
    logic signed [PHASE_W-1:0] phase_i;
    logic                      valid_o;
    logic                      mode_o;
    logic signed [DATA_W:0]    x_o;
    logic signed [DATA_W:0]    y_o;
    logic signed [PHASE_W-1:0] phase_o;
    logic                      busy_o;

    modport master (output clk_en_i, valid_i, mode_i, x_i, y_i, phase_i,
                    input  valid_o, mode_o, x_o, y_o, phase_o, busy_o);
    modport slave  (input  clk_en_i, valid_i, mode_i, x_i, y_i, phase_i,
                    output valid_o, mode_o, x_o, y_o, phase_o, busy_o);
endinterface

// File: rtl/fg_cordic_pipe.sv
// Fully pipelined rotation/vectoring CORDIC with valid/mode tagging, optional
// gain compensation and saturated outputs.
module fg_cordic_pipe #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PHASE_W   = 10,
    parameter int unsigned STAGES    = 7,
    parameter int unsigned GAIN_COMP = 0
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    fg_cordic_pipe_if.slave bus
);
    localparam int unsigned IW = DATA_W + 2;
    localparam int unsigned OW = DATA_W + 1;
    localparam int unsigned PW = PHASE_W;
    localparam logic signed [PW-1:0] QTR = PW'(32'd1 << (PW - 2));

    typedef struct packed {
        logic          vld;
        logic          mode;
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        logic [PW-1:0] z;
    } stage_t;

    // atan(2^-i) in 16-bit units (45 deg = 8192), rounded half-up to PW bits
    function automatic logic signed [PW-1:0] atan_f(input int i);
        int a16;
        int sh;
        logic signed [PW-1:0] r;
        case (i)
            0: a16 = 8192;  1: a16 = 4836;  2: a16 = 2555;  3: a16 = 1297;
            4: a16 = 651;   5: a16 = 326;   6: a16 = 163;   7: a16 = 81;
            8: a16 = 41;    9: a16 = 20;   10: a16 = 10;   11: a16 = 5;
            default: a16 = 0;
        endcase
        sh = 16 - int'(PW);
        if (sh <= 0) r = PW'(a16);
        else         r = PW'((a16 + (1 << (sh - 1))) >> sh);
        return r;
    endfunction

    function automatic logic signed [IW-1:0] gain_f(input logic signed [IW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction

    // IW is one bit wider than OW, so overflow shows as disagreeing top bits
    function automatic logic signed [OW-1:0] sat_f(input logic signed [IW-1:0] v);
        logic signed [OW-1:0] r;
        if (v[IW-1] != v[IW-2]) r = v[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else                    r = v[OW-1:0];
        return r;
    endfunction

    stage_t               pre_c;
    stage_t               st_q  [STAGES];
    stage_t               rot_c [STAGES];
    stage_t               tail_c;
    logic signed [IW-1:0] xe_c, ye_c;
    logic signed [IW-1:0] xs_c, ys_c, dx_c, dy_c;
    logic signed [PW-1:0] zs_c;
    logic                 cw_c;
    logic                 busy_nxt_c;

    // Quadrant pre-rotation brings the vector within reach of the micro-rotations
    always_comb begin
        xe_c       = IW'(bus.x_i);
        ye_c       = IW'(bus.y_i);
        pre_c      = '0;
        pre_c.vld  = bus.valid_i;
        pre_c.mode = bus.mode_i;
        pre_c.x    = xe_c;
        pre_c.y    = ye_c;
        if (!bus.mode_i) begin
            pre_c.z = bus.phase_i;
            case (bus.phase_i[PW-1 -: 2])
                2'b01: begin
                    pre_c.x = -ye_c;
                    pre_c.y = xe_c;
                    pre_c.z = {2'b00, bus.phase_i[PW-3:0]};
                end
                2'b10: begin
                    pre_c.x = ye_c;
                    pre_c.y = -xe_c;
                    pre_c.z = {2'b11, bus.phase_i[PW-3:0]};
                end
                default: ;
            endcase
        end else if (xe_c[IW-1]) begin
            if (!ye_c[IW-1]) begin
                pre_c.x = ye_c;
                pre_c.y = -xe_c;
                pre_c.z = QTR;
            end else begin
                pre_c.x = -ye_c;
                pre_c.y = xe_c;
                pre_c.z = -QTR;
            end
        end
    end

    // Micro-rotation i operates on stage register i
    always_comb begin
        xs_c = '0;
        ys_c = '0;
        dx_c = '0;
        dy_c = '0;
        zs_c = '0;
        cw_c = 1'b0;
        for (int i = 0; i < int'(STAGES); i++) begin
            xs_c     = st_q[i].x;
            ys_c     = st_q[i].y;
            zs_c     = st_q[i].z;
            cw_c     = st_q[i].mode ? !ys_c[IW-1] : zs_c[PW-1];
            dx_c     = ys_c >>> i;
            dy_c     = xs_c >>> i;
            rot_c[i] = st_q[i];
            if (cw_c) begin
                rot_c[i].x = xs_c + dx_c;
                rot_c[i].y = ys_c - dy_c;
                rot_c[i].z = zs_c + atan_f(i);
            end else begin
                rot_c[i].x = xs_c - dx_c;
                rot_c[i].y = ys_c + dy_c;
                rot_c[i].z = zs_c - atan_f(i);
            end
        end
    end

    if (GAIN_COMP != 0) begin : g_gain
        stage_t gain_q;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i)             gain_q <= '0;
            else if (bus.clk_en_i)   gain_q <= rot_c[STAGES-1];
        end

        always_comb begin
            tail_c   = gain_q;
            tail_c.x = gain_f(gain_q.x);
            tail_c.y = gain_f(gain_q.y);
        end
    end else begin : g_nogain
        always_comb tail_c = rot_c[STAGES-1];
    end

    // busy reflects every valid flag after the coming advance
    always_comb begin
        busy_nxt_c = pre_c.vld | tail_c.vld;
        for (int i = 0; i < int'(STAGES); i++) busy_nxt_c = busy_nxt_c | st_q[i].vld;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(STAGES); i++) st_q[i] <= '0;
            bus.valid_o <= 1'b0;
            bus.mode_o  <= 1'b0;
            bus.x_o     <= '0;
            bus.y_o     <= '0;
            bus.phase_o <= '0;
            bus.busy_o  <= 1'b0;
        end else if (bus.clk_en_i) begin
            st_q[0] <= pre_c;
            for (int i = 1; i < int'(STAGES); i++) st_q[i] <= rot_c[i-1];
            bus.valid_o <= tail_c.vld;
            bus.mode_o  <= tail_c.mode;
            bus.x_o     <= sat_f(tail_c.x);
            bus.y_o     <= sat_f(tail_c.y);
            bus.phase_o <= tail_c.z;
            bus.busy_o  <= busy_nxt_c;
        end
    end
endmodule

// File: tb/tb_fg_cordic_pipe.sv
// Self-checking bench: default and gain-compensated cores driven with identical
// stimulus and compared every cycle against an integer CORDIC reference.
module tb_fg_cordic_pipe;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 10;
    localparam int          ST = 7;
    localparam int          L0 = 1 + ST;
    localparam int          L1 = 2 + ST;
    localparam int          ATAN [7] = '{128, 76, 40, 20, 10, 5, 3};

    typedef struct {
        bit vld;
        bit mode;
        int x;
        int y;
        int z;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t cur0, cur1;

    fg_cordic_pipe_if #(.DATA_W(DW), .PHASE_W(PW)) if0 ();
    fg_cordic_pipe_if #(.DATA_W(DW), .PHASE_W(PW)) if1 ();

    fg_cordic_pipe #(.DATA_W(DW), .PHASE_W(PW), .STAGES(ST), .GAIN_COMP(0)) dut0 (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (if0)
    );
    fg_cordic_pipe #(.DATA_W(DW), .PHASE_W(PW), .STAGES(ST), .GAIN_COMP(1)) dut1 (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrapz(input int z);
        int r;
        r = z % 1024;
        if (r >= 512)  r -= 1024;
        if (r < -512)  r += 1024;
        return r;
    endfunction

    function automatic int sat9(input int v);
        if (v > 255)  return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    function automatic int gainv(input int v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction

    // Reference: quarter-turn pre-rotation, then ST shift-add rotations
    function automatic exp_t model(input bit vld, input bit m, input int xi, input int yi,
                                   input int ph, input bit gain);
        exp_t e;
        int x, y, z, t;
        bit cw;
        x = xi; y = yi; z = 0;
        if (!m) begin
            z = ph;
            if (ph >= 256)       begin t = x; x = -y; y = t;  z = ph - 256; end
            else if (ph < -256)  begin t = x; x = y;  y = -t; z = ph + 256; end
        end else if (x < 0) begin
            t = x;
            if (y >= 0) begin x = y;  y = -t; z = 256;  end
            else        begin x = -y; y = t;  z = -256; end
        end
        for (int i = 0; i < ST; i++) begin
            cw = m ? (y >= 0) : (z < 0);
            t  = x;
            if (cw) begin x = x + (y >>> i); y = y - (t >>> i); z = z + ATAN[i]; end
            else    begin x = x - (y >>> i); y = y + (t >>> i); z = z - ATAN[i]; end
            z = wrapz(z);
        end
        if (gain) begin x = gainv(x); y = gainv(y); end
        e.vld = vld; e.mode = m; e.x = sat9(x); e.y = sat9(y); e.z = wrapz(z);
        return e;
    endfunction

    function automatic bit any_valid(input exp_t q [$], input exp_t c);
        bit b;
        b = c.vld;
        foreach (q[i]) b = b | q[i].vld;
        return b;
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic reset_model();
        exp_t idle;
        idle = '{vld: 1'b0, mode: 1'b0, x: 0, y: 0, z: 0};
        q0.delete();
        q1.delete();
        for (int i = 0; i < L0 - 1; i++) q0.push_back(idle);
        for (int i = 0; i < L1 - 1; i++) q1.push_back(idle);
        cur0 = idle;
        cur1 = idle;
    endtask

    task automatic drive(input bit en, input bit v, input bit m, input int x, input int y, input int ph);
        if0.clk_en_i = en; if0.valid_i = v; if0.mode_i = m;
        if0.x_i = DW'(x);  if0.y_i = DW'(y); if0.phase_i = PW'(ph);
        if1.clk_en_i = en; if1.valid_i = v; if1.mode_i = m;
        if1.x_i = DW'(x);  if1.y_i = DW'(y); if1.phase_i = PW'(ph);
    endtask

    task automatic compare_all();
        chk("g0.valid_o", if0.valid_o, int'(cur0.vld));
        chk("g0.busy_o",  if0.busy_o,  int'(any_valid(q0, cur0)));
        if (cur0.vld) begin
            chk("g0.mode_o",  if0.mode_o,  int'(cur0.mode));
            chk("g0.x_o",     if0.x_o,     cur0.x);
            chk("g0.y_o",     if0.y_o,     cur0.y);
            chk("g0.phase_o", if0.phase_o, cur0.z);
        end
        chk("g1.valid_o", if1.valid_o, int'(cur1.vld));
        chk("g1.busy_o",  if1.busy_o,  int'(any_valid(q1, cur1)));
        if (cur1.vld) begin
            chk("g1.mode_o",  if1.mode_o,  int'(cur1.mode));
            chk("g1.x_o",     if1.x_o,     cur1.x);
            chk("g1.y_o",     if1.y_o,     cur1.y);
            chk("g1.phase_o", if1.phase_o, cur1.z);
        end
    endtask

    // One clock: apply inputs, advance the reference on enabled edges, compare
    task automatic step(input bit en, input bit v, input bit m, input int x, input int y, input int ph);
        drive(en, v, m, x, y, ph);
        @(posedge clk);
        if (en) begin
            q0.push_back(model(v, m, x, y, ph, 1'b0));
            q1.push_back(model(v, m, x, y, ph, 1'b1));
            cur0 = q0.pop_front();
            cur1 = q1.pop_front();
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic directed(input string nm, input bit m, input int x, input int y, input int ph,
                            output int x0, output int y0, output int z0,
                            output int x1, output int y1);
        int lat0, lat1;
        lat0 = -1; lat1 = -1;
        x0 = 0; y0 = 0; z0 = 0; x1 = 0; y1 = 0;
        step(1'b1, 1'b1, m, x, y, ph);
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
            if (if0.valid_o === 1'b1 && lat0 < 0) begin
                lat0 = n; x0 = int'(if0.x_o); y0 = int'(if0.y_o); z0 = int'(if0.phase_o);
            end
            if (if1.valid_o === 1'b1 && lat1 < 0) begin
                lat1 = n; x1 = int'(if1.x_o); y1 = int'(if1.y_o);
            end
        end
        chk({nm, ".lat0"}, lat0, L0);
        chk({nm, ".lat1"}, lat1, L1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst.g0.valid_o", if0.valid_o, 0);
        chk("rst.g0.busy_o",  if0.busy_o,  0);
        chk("rst.g1.valid_o", if1.valid_o, 0);
        chk("rst.g1.busy_o",  if1.busy_o,  0);
        reset_model();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, y0, z0, x1, y1;
        int rx, ry, rph;
        bit rm;
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        reset_model();
        @(negedge clk);
        chk("reset.valid_o", if0.valid_o, 0);
        chk("reset.busy_o",  if0.busy_o,  0);
        chk("reset.mode_o",  if0.mode_o,  0);
        chk("reset.x_o",     if0.x_o,     0);
        chk("reset.y_o",     if0.y_o,     0);
        chk("reset.phase_o", if0.phase_o, 0);
        chk("reset.g1.valid_o", if1.valid_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);

        // Hand-computed 7-stage results
        directed("rot0", 1'b0, 100, 0, 0, x0, y0, z0, x1, y1);
        chk("rot0.x", x0, 165); chk("rot0.y", y0, 0); chk("rot0.z", z0, 0);
        directed("rot90", 1'b0, 100, 0, 256, x0, y0, z0, x1, y1);
        chk("rot90.x", x0, 0); chk("rot90.y", y0, 166);
        directed("rotm90", 1'b0, 100, 0, -256, x0, y0, z0, x1, y1);
        chk("rotm90.x", x0, -1); chk("rotm90.y", y0, -165);
        directed("rot180", 1'b0, 100, 0, -512, x0, y0, z0, x1, y1);
        chk("rot180.x", x0, -166); chk("rot180.y", y0, 1);
        directed("vec45", 1'b1, 100, 100, 0, x0, y0, z0, x1, y1);
        chk("vec45.x", x0, 236); chk("vec45.z", z0, 126);
        directed("vec180", 1'b1, -100, 0, 0, x0, y0, z0, x1, y1);
        chk("vec180.x", x0, 165); chk("vec180.y", y0, 0); chk("vec180.z", z0, -512);
        directed("gain45", 1'b0, 100, 0, 128, x0, y0, z0, x1, y1);
        chk("gain45.x1", x1, 71); chk("gain45.y1", y1, 72);
        chk("gain45.x0", x0, 116); chk("gain45.y0", y0, 118);
        directed("sat", 1'b1, 127, 127, 0, x0, y0, z0, x1, y1);
        chk("sat.x", x0, 255);

        // Random traffic with random enable and valid gaps
        for (int k = 0; k < 400; k++) begin
            rx  = int'($urandom_range(0, 255)) - 128;
            ry  = int'($urandom_range(0, 255)) - 128;
            rph = int'($urandom_range(0, 1023)) - 512;
            rm  = 1'($urandom_range(0, 1));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rm, rx, ry, rph);
        end
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);

        // 20 back-to-back samples with clk_en toggling every cycle
        rx = 0; ry = 0; rph = 0; rm = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) begin
                rx  = int'($urandom_range(0, 255)) - 128;
                ry  = int'($urandom_range(0, 255)) - 128;
                rph = int'($urandom_range(0, 1023)) - 512;
                rm  = 1'($urandom_range(0, 1));
            end
            step(k % 2 == 0, 1'b1, rm, rx, ry, rph);
        end
        for (int k = 0; k < 24; k++) step(k % 2 == 0, 1'b0, 1'b0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);

        // Reset with five samples in flight
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 100, 0, 50 * k);
        do_reset();
        for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fg_cordic_pipe.md
Name: fg_cordic_pipe

Overview:
- Parametrised, fully pipelined CORDIC engine for the function generator. Successor to the fixed 8-bit rotation-only core.
- Adds run-time rotation/vectoring mode per sample, valid tagging through the pipe, configurable stage count, optional gain compensation, and saturated outputs.
- Sits between the phase accumulator/waveform select logic and the output DAC formatter. Also serves amplitude/phase measurement in vectoring mode.

Parameters:
- DATA_W, 8: signed input width of x/y.
- PHASE_W, 10: signed phase width. Full circle = 2^PHASE_W; top 2 bits = quadrant. Legal range 8..16.
- STAGES, 7: number of micro-rotation stages. Legal range 1..12.
- GAIN_COMP, 0: 1 adds a shift-add stage multiplying by K≈0.607422.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous, active-low reset.
- clk_en_i  in  1  global pipeline advance enable.
- valid_i  in  1  input sample valid.
- mode_i  in  1  0 = rotation, 1 = vectoring.
- x_i  in  DATA_W  signed x input.
- y_i  in  DATA_W  signed y input.
- phase_i  in  PHASE_W  signed angle input; used in rotation mode, ignored in vectoring.
- valid_o  out  1  output sample valid.
- mode_o  out  1  mode tag delayed with the sample.
- x_o  out  DATA_W+1  cosine (rotation) or magnitude (vectoring), saturated.
- y_o  out  DATA_W+1  sine (rotation) or residual (vectoring), saturated.
- phase_o  out  PHASE_W  residual angle (rotation) or measured angle (vectoring).
- busy_o  out  1  OR of all internal stage valid flags.

Behaviour:
- Reset: all stage registers, valid flags, mode tags and outputs go to 0 asynchronously. This includes valid_o=0 and busy_o=0. A reset mid-stream discards every in-flight sample.
- clk_en_i=0: every register holds, including valid flags. clk_en_i=1: all stages advance one position.
- Latency: 1 + STAGES + GAIN_COMP enabled cycles from input capture to output. Defaults give 8. Throughput is one sample per enabled cycle. There is no backpressure.
- valid_i=0 samples still propagate, with valid=0. Data in those slots is don't-care.
- Internal x/y width is DATA_W+2, sign-extended from the inputs. Phase width is PHASE_W. Phase arithmetic wraps modulo 2^PHASE_W.
- Stage 0, pre-rotation, rotation mode:
  - quadrant 00/11: pass through.
  - 01: (x,y) ← (-y,x); z ← {00, phase_i[PHASE_W-3:0]}.
  - 10: (x,y) ← (y,-x); z ← {11, phase_i[PHASE_W-3:0]}.
- Stage 0, pre-rotation, vectoring mode:
  - x≥0: pass through, z ← 0.
  - x<0, y≥0: (x,y) ← (y,-x), z ← +2^(PHASE_W-2).
  - x<0, y<0: (x,y) ← (-y,x), z ← -2^(PHASE_W-2).
- Stage i (0..STAGES-1):
  - Clockwise step when (rotation and z<0) or (vectoring and y≥0): x+=y>>>i, y-=x>>>i, z+=atan[i].
  - Otherwise: x-=y>>>i, y+=x>>>i, z-=atan[i].
- atan table: 16-bit constants for 45° = 8192: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5. Each is reduced to PHASE_W by an arithmetic shift right of 16-PHASE_W with round-half-up. For PHASE_W=10 the first entries are 128, 76, 40, 20, 10, 5, 3.
- Gain stage (GAIN_COMP=1): v ← (v>>>1)+(v>>>3)−(v>>>6)−(v>>>9), applied to x and y. z, valid and mode are delayed by one.
- Output: x/y saturate to [−2^DATA_W, 2^DATA_W−1]. No flag is raised on saturation. phase_o is passed through unsaturated.
- Without gain compensation, outputs carry the CORDIC gain ≈1.6468.

Test Plan:
- Rotation, defaults, x=100, y=0, phase=0, valid_i=1 for 1 cycle → exactly 8 enabled cycles later valid_o=1 for 1 cycle; x_o=165±3, y_o=0±3, mode_o=0.
- Rotation, phase=256 (90°), x=100, y=0 → y_o=165±3, x_o=0±3. Phase=−256 → y_o=−165±3. Phase=−512 → x_o=−165±3.
- Vectoring, x=100, y=100 → x_o=233±3, phase_o=128±2. Vectoring x=−100, y=0 → x_o=165±3, phase_o=−512 (wrap) ±2.
- GAIN_COMP=1, rotation x=100, y=0, phase=128 → latency 9; x_o=71±3, y_o=71±3. Defaults with x=127, y=127 in vectoring → x_o saturates to 255.
- Stream 20 back-to-back valid samples while toggling clk_en_i 1/0 every other cycle → outputs arrive in order, each after 8 enabled edges; valid pattern preserved; outputs hold while clk_en_i=0.
- Assert rstn_i low for 1 cycle with 5 samples in flight → valid_o and busy_o drop to 0 immediately and no stale sample emerges afterwards.
